// File: rtl/dm_access_ctrl.sv
// Single-outstanding load/store initiator for the 16-bit data memory port.
// Define DM_RANGE_CHECK_EN to reject requests whose address is >= MEM_DEPTH.
module dm_access_ctrl #(
    parameter int MEM_RD_LAT = 1,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        we_DM,
    output logic [15:0] addrDM,
    output logic [15:0] dataDM,
    input  logic [15:0] outDM
);

`ifdef DM_RANGE_CHECK_EN
    localparam logic RANGE_CHECK = 1'b1;
`else
    localparam logic RANGE_CHECK = 1'b0;
`endif

    localparam logic [2:0] RD_LAST = 3'(MEM_RD_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_dm_q, we_dm_d;
    logic [15:0] addr_dm_q, addr_dm_d;
    logic [15:0] data_dm_q, data_dm_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        accept;
    logic        addr_oob;
    logic        rd_done;
    logic        rsp_fire;

    // Both channels transfer on a posedge where valid && ready; the source
    // holds its payload stable while valid is high and ready is low.
    assign accept   = req_valid && req_ready;
    assign rsp_fire = rsp_valid_q && rsp_ready;
    assign addr_oob = RANGE_CHECK && ({16'd0, req_addr} >= 32'(MEM_DEPTH));
    assign rd_done  = (cnt_q == RD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            we_dm_q     <= 1'b0;
            addr_dm_q   <= 16'd0;
            data_dm_q   <= 16'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_dm_q     <= we_dm_d;
            addr_dm_q   <= addr_dm_d;
            data_dm_q   <= data_dm_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (addr_oob) begin
                        state_d = S_RESP;
                    end else if (req_we) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: state_d = S_RESP;
            S_READ: begin
                if (rd_done) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory-side outputs are loaded at acceptance so they are valid from the
    // first WRITE/READ cycle; the address is never touched outside acceptance.
    always_comb begin
        cnt_d       = cnt_q;
        we_dm_d     = 1'b0;
        addr_dm_d   = addr_dm_q;
        data_dm_d   = data_dm_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = 3'd0;
                    if (addr_oob) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 16'd0;
                        rsp_err_d   = 1'b1;
                    end else if (req_we) begin
                        we_dm_d   = 1'b1;
                        addr_dm_d = req_addr;
                        data_dm_d = req_wdata;
                    end else begin
                        addr_dm_d = req_addr;
                    end
                end
            end
            S_WRITE: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = 16'd0;
                rsp_err_d   = 1'b0;
            end
            S_READ: begin
                if (rd_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = outDM;
                    rsp_err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_RESP: begin
                if (rsp_fire) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    assign req_ready = rst_n && (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign we_DM     = we_dm_q;
    assign addrDM    = addr_dm_q;
    assign dataDM    = data_dm_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: directed and random loads/stores against a
// word-addressed reference memory and per-request latency rules.
module tb_dm_access_ctrl;
  localparam int MEM_RD_LAT = 1;
  localparam int MEM_DEPTH  = 1024;
`ifdef DM_RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        we_DM;
  logic [15:0] addrDM;
  logic [15:0] dataDM;
  logic [15:0] outDM;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] ref_mem [logic [15:0]];

  logic        mem_clr;
  logic [15:0] mem [0:65535];
  logic [15:0] rd_pipe [0:MEM_RD_LAT-1];

  dm_access_ctrl #(
    .MEM_RD_LAT(MEM_RD_LAT),
    .MEM_DEPTH (MEM_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .we_DM    (we_DM),
    .addrDM   (addrDM),
    .dataDM   (dataDM),
    .outDM    (outDM)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  // downstream data memory with registered read latency
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 16'h0;
    end else if (we_DM) begin
      mem[addrDM] <= dataDM;
    end
    rd_pipe[0] <= mem[addrDM];
    for (int i = 1; i < MEM_RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign outDM = rd_pipe[MEM_RD_LAT-1];

  always @(negedge clk) begin
    if (we_DM === 1'b1) we_cnt++;
  end

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: called at a negedge; runs one request through to its response
  task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input int bp, input logic nxt_v, input logic [15:0] nxt_addr,
                       input logic [15:0] nxt_wdata);
    int          waited;
    int          lat;
    int          pulses0;
    logic        oob;
    logic        is_store;
    logic [15:0] exp_rd;
    oob      = RANGE_EN && ({16'd0, addr} >= 32'(MEM_DEPTH));
    is_store = we && !oob;
    lat      = oob ? 1 : (we ? 2 : MEM_RD_LAT + 2);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    waited = 0;
    while (!req_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    chk1("accept_wait", waited < 64, 1'b1);
    if (waited >= 64) begin
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back((oob || we) ? 16'h0 : ref_read(addr));
    if (is_store) ref_mem[addr] = wdata;
    pulses0 = we_cnt;
    @(negedge clk);
    if (nxt_v) begin
      req_we    = 1'b1;
      req_addr  = nxt_addr;
      req_wdata = nxt_wdata;
    end else begin
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_addr  = 16'($urandom);
      req_wdata = 16'($urandom);
    end
    for (int k = 1; k < lat; k++) begin
      chk1("busy_req_ready", req_ready, 1'b0);
      chk1("early_rsp_valid", rsp_valid, 1'b0);
      chk1("we_pulse", we_DM, is_store && (k == 1));
      if (is_store && k == 1) begin
        chk16("wr_addr", addrDM, addr);
        chk16("wr_data", dataDM, wdata);
      end
      if (!we && !oob) chk16("rd_addr_hold", addrDM, addr);
      @(negedge clk);
    end
    exp_rd = exp_q.pop_front();
    for (int b = 0; b <= bp; b++) begin
      if (b == bp) rsp_ready = 1'b1;
      chk1("rsp_valid", rsp_valid, 1'b1);
      chk16("rsp_rdata", rsp_rdata, exp_rd);
      chk1("rsp_err", rsp_err, oob);
      chk1("resp_req_ready", req_ready, 1'b0);
      chk1("resp_we_low", we_DM, 1'b0);
      if (!oob) chk16("resp_addr_hold", addrDM, addr);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk1("rsp_done", rsp_valid, 1'b0);
    chk1("idle_req_ready", req_ready, 1'b1);
    chk16("we_pulse_count", 16'(we_cnt - pulses0), 16'(is_store));
  endtask

  initial begin
    logic        r_we;
    logic [15:0] r_addr;
    rst_n     = 1'b0;
    mem_clr   = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h1234;
    req_wdata = 16'h5678;
    rsp_ready = 1'b0;

    // reset held with a pending request
    repeat (3) begin
      @(negedge clk);
      chk1("rst_req_ready", req_ready, 1'b0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk1("rst_we_dm", we_DM, 1'b0);
      chk16("rst_addr_dm", addrDM, 16'h0);
      chk16("rst_data_dm", dataDM, 16'h0);
      chk16("rst_rsp_rdata", rsp_rdata, 16'h0);
      chk1("rst_rsp_err", rsp_err, 1'b0);
    end
    rst_n     = 1'b1;
    mem_clr   = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk1("post_rst_req_ready", req_ready, 1'b1);
    chk1("post_rst_rsp_valid", rsp_valid, 1'b0);

    // store then load
    issue(1'b1, 16'h0005, 16'h1DFE, 0, 1'b0, 16'h0, 16'h0);
    issue(1'b0, 16'h0005, 16'h0000, 0, 1'b0, 16'h0, 16'h0);

    // response backpressure on a load
    issue(1'b1, 16'h0001, 16'hA001, 0, 1'b0, 16'h0, 16'h0);
    issue(1'b0, 16'h0001, 16'h0000, 5, 1'b0, 16'h0, 16'h0);

    // back-to-back stores with req_valid held high
    issue(1'b1, 16'h0010, 16'hB010, 0, 1'b1, 16'h0011, 16'hB011);
    issue(1'b1, 16'h0011, 16'hB011, 0, 1'b1, 16'h0012, 16'hB012);
    issue(1'b1, 16'h0012, 16'hB012, 0, 1'b0, 16'h0, 16'h0);
    issue(1'b0, 16'h0011, 16'h0000, 1, 1'b0, 16'h0, 16'h0);

    // rsp_ready with nothing pending
    rsp_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk1("idle_rsp_valid", rsp_valid, 1'b0);
      chk1("idle_ready_hold", req_ready, 1'b1);
    end
    rsp_ready = 1'b0;

    // reset in the middle of a load
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0005;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk1("midrst_rsp_valid", rsp_valid, 1'b0);
      chk1("midrst_we_dm", we_DM, 1'b0);
      chk1("midrst_req_ready", req_ready, 1'b0);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk1("after_rst_no_rsp", rsp_valid, 1'b0);
      chk1("after_rst_ready", req_ready, 1'b1);
    end
    issue(1'b0, 16'h0005, 16'h0000, 0, 1'b0, 16'h0, 16'h0);

    // address boundaries around MEM_DEPTH and the top of the address space
    issue(1'b1, 16'h0400, 16'hC400, 0, 1'b0, 16'h0, 16'h0);
    issue(1'b0, 16'h0400, 16'h0000, 0, 1'b0, 16'h0, 16'h0);
    issue(1'b1, 16'h03FF, 16'hC3FF, 0, 1'b0, 16'h0, 16'h0);
    issue(1'b0, 16'h03FF, 16'h0000, 0, 1'b0, 16'h0, 16'h0);
    issue(1'b1, 16'hFFFF, 16'h5AA5, 2, 1'b0, 16'h0, 16'h0);
    issue(1'b0, 16'hFFFF, 16'h0000, 0, 1'b0, 16'h0, 16'h0);

    // random mix of loads and stores with random backpressure
    for (int i = 0; i < 60; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'h03F0, 16'hFFFF))
                                           : 16'($urandom_range(0, 15));
      issue(r_we, r_addr, 16'($urandom), $urandom_range(0, 3), 1'b0, 16'h0, 16'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
